// File: rtl/const_field_assembler.sv
// const_field_assembler: gathers little-endian instruction bytes into a sign- or zero-extended constant
module const_field_assembler #(
    parameter int MQ_N      = 4,
    parameter int IMM_W     = 64,
    parameter int MAX_BYTES = 8,
    parameter int SW        = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SW-1:0]    start_size,
    input  logic [MQ_N-1:0]  start_to,
    input  logic             start_sext,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IMM_W-1:0] out_value,
    output logic [MQ_N-1:0]  out_to,
    output logic [SW-1:0]    out_nbytes,
    output logic             busy,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t            state_q;
    logic [SW-1:0]     size_q;
    logic [SW-1:0]     cnt_q;
    logic [MQ_N-1:0]   to_q;
    logic              sext_q;
    logic              err_q;
    logic [IMM_W-1:0]  acc_q;
    logic [IMM_W-1:0]  val_q;
    logic [IMM_W-1:0]  acc_d;
    logic [IMM_W-1:0]  mask_d;
    logic [IMM_W-1:0]  val_d;
    logic [SW+2:0]     nbits_d;
    logic              sign_d;
    logic              last_d;

    // Drop the incoming byte into its lane and form the extended result used when the field completes
    always_comb begin
        acc_d   = acc_q | (IMM_W'(byte_data) << {cnt_q, 3'b000});
        nbits_d = {size_q, 3'b000};
        mask_d  = ~({IMM_W{1'b1}} << nbits_d);
        sign_d  = sext_q & (|(acc_d & (IMM_W'(1) << (nbits_d - (SW+3)'(1)))));
        val_d   = sign_d ? (acc_d | ~mask_d) : (acc_d & mask_d);
        last_d  = (cnt_q + SW'(1)) == size_q;
    end

    assign byte_ready = state_q == COLLECT;
    assign out_valid  = state_q == HOLD;
    assign busy       = state_q != IDLE;
    assign err        = err_q;
    assign out_value  = val_q;
    assign out_to     = to_q;
    assign out_nbytes = cnt_q;

    // Field sequencing: accept a start, collect bytes until the latched size is reached, then hold the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            size_q  <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            val_q   <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    if (start_size > SW'(MAX_BYTES)) begin
                        err_q <= 1'b1;
                    end else begin
                        size_q  <= start_size;
                        to_q    <= start_to;
                        sext_q  <= start_sext;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        val_q   <= '0;
                        state_q <= (start_size == '0) ? HOLD : COLLECT;
                    end
                end
                COLLECT: if (byte_valid) begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + SW'(1);
                    if (last_d) begin
                        val_q   <= val_d;
                        state_q <= HOLD;
                    end
                end
                HOLD: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_const_field_assembler.sv
// tb_const_field_assembler: directed stimulus with an arithmetic reference model checked every cycle
module tb_const_field_assembler;
    logic        clk, rst, start, start_sext, byte_valid, out_ready;
    logic [3:0]  start_size, start_to;
    logic [7:0]  byte_data;
    logic        byte_ready, out_valid, busy, err;
    logic [63:0] out_value;
    logic [3:0]  out_to, out_nbytes;

    int vecs = 0;
    int miss = 0;

    const_field_assembler dut (
        .clk(clk), .rst(rst), .start(start), .start_size(start_size), .start_to(start_to),
        .start_sext(start_sext), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .out_to(out_to), .out_nbytes(out_nbytes), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 collecting, 2 holding; value built as sum of byte*256^n
    int              m_st, m_size, m_cnt;
    bit              m_sext, m_err;
    logic [3:0]      m_to;
    longint unsigned m_acc, m_pow;

    always @(posedge clk or posedge rst) begin : model
        int st, cnt;
        bit er;
        longint unsigned acc, pow;
        if (rst) begin
            m_st <= 0; m_err <= 0; m_cnt <= 0; m_acc <= 0; m_pow <= 1;
            m_to <= 0; m_size <= 0; m_sext <= 0;
        end else begin
            st = m_st; cnt = m_cnt; acc = m_acc; pow = m_pow; er = 0;
            if (st == 0 && start) begin
                if (start_size > 8) er = 1;
                else begin
                    m_size <= int'(start_size); m_sext <= start_sext; m_to <= start_to;
                    acc = 0; pow = 1; cnt = 0;
                    st = (start_size == 0) ? 2 : 1;
                end
            end else if (st == 1 && byte_valid) begin
                acc = acc + 64'(byte_data) * pow;
                pow = pow * 256;
                cnt = cnt + 1;
                if (cnt == m_size) begin
                    if (m_sext && byte_data >= 8'd128 && m_size < 8) acc = acc - pow;
                    st = 2;
                end
            end else if (st == 2 && out_ready) st = 0;
            m_st <= st; m_cnt <= cnt; m_acc <= acc; m_pow <= pow; m_err <= er;
        end
    end

    // Every cycle, away from the active edge, compare all outputs with the model
    always @(negedge clk) begin
        chk("byte_ready", 64'(byte_ready), 64'(m_st == 1));
        chk("out_valid", 64'(out_valid), 64'(m_st == 2));
        chk("busy", 64'(busy), 64'(m_st != 0));
        chk("err", 64'(err), 64'(m_err));
        if (rst || m_st == 2) begin
            chk("out_value", out_value, m_acc);
            chk("out_to", 64'(out_to), 64'(m_to));
            chk("out_nbytes", 64'(out_nbytes), 64'(m_cnt));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic begin_field(input logic [3:0] sz, input logic sx, input logic [3:0] to);
        start = 1; start_size = sz; start_sext = sx; start_to = to;
        tick;
        start = 0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1; byte_data = b;
        tick;
        byte_valid = 0;
    endtask

    task automatic release_out;
        out_ready = 1;
        tick;
        out_ready = 0;
    endtask

    initial begin
        rst = 1; start = 0; start_size = 0; start_to = 0; start_sext = 0;
        byte_valid = 0; byte_data = 0; out_ready = 0;
        tick; tick;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset value", out_value, 64'd0);
        rst = 0;
        tick;

        begin_field(4'd4, 1'b0, 4'b0001);
        send(8'h78); send(8'h56); send(8'h34);
        chk("c4 no valid", 64'(out_valid), 64'd0);
        send(8'h12);
        chk("c5 valid", 64'(out_valid), 64'd1);
        chk("r036 value", out_value, 64'h0000000012345678);
        chk("r036 nbytes", 64'(out_nbytes), 64'd4);
        chk("r036 to", 64'(out_to), 64'b0001);
        out_ready = 1; start = 1; start_size = 4'd9;
        tick;
        out_ready = 0; start = 0;
        chk("bubble no err", 64'(err), 64'd0);
        chk("bubble idle", 64'(busy), 64'd0);

        begin_field(4'd1, 1'b1, 4'b0010);
        send(8'hF0);
        chk("r037 sext", out_value, 64'hFFFFFFFFFFFFFFF0);
        release_out;
        begin_field(4'd1, 1'b0, 4'b0100);
        send(8'hF0);
        chk("r037 zext", out_value, 64'h00000000000000F0);
        release_out;

        begin_field(4'd2, 1'b1, 4'b1000);
        send(8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("gap ready", 64'(byte_ready), 64'd1);
            tick;
        end
        send(8'h80);
        for (int i = 0; i < 4; i++) begin
            chk("r038 hold", out_value, 64'hFFFFFFFFFFFF8000);
            tick;
        end
        release_out;

        start = 1; start_size = 4'd9;
        tick;
        start = 0;
        chk("r039 err", 64'(err), 64'd1);
        chk("r039 busy", 64'(busy), 64'd0);
        tick;
        chk("r039 err pulse", 64'(err), 64'd0);
        begin_field(4'd0, 1'b1, 4'b0011);
        byte_valid = 1; byte_data = 8'hAA;
        chk("size0 valid", 64'(out_valid), 64'd1);
        chk("size0 value", out_value, 64'd0);
        chk("size0 ready", 64'(byte_ready), 64'd0);
        tick;
        byte_valid = 0;
        release_out;

        begin_field(4'd8, 1'b1, 4'b0000);
        for (int i = 1; i <= 8; i++) send(8'(i * 16'h11));
        chk("full width", out_value, 64'h8877665544332211);
        chk("to zero", 64'(out_to), 64'd0);
        release_out;

        begin_field(4'd8, 1'b0, 4'b0101);
        send(8'h01); send(8'h02); send(8'h03);
        #1 rst = 1;
        #1;
        chk("async rdy", 64'(byte_ready), 64'd0);
        chk("async busy", 64'(busy), 64'd0);
        chk("async value", out_value, 64'd0);
        chk("async to", 64'(out_to), 64'd0);
        chk("async nbytes", 64'(out_nbytes), 64'd0);
        tick;
        rst = 0;
        tick;
        begin_field(4'd1, 1'b1, 4'b0001);
        send(8'h7F);
        chk("r040 value", out_value, 64'h7F);
        chk("r040 nbytes", 64'(out_nbytes), 64'd1);
        begin_field(4'd0, 1'b0, 4'b0010);
        #1 rst = 1;
        tick;
        rst = 0;
        tick; tick;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
